core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle control FSM for the single-issue RV32I core. Fetches instructions and holds the instruction register.
//  Issues the register-file read capture, execute, memory and writeback strobes that drive the ALU/register-file datapath.
//  Computes the next PC, halts on ECALL/EBREAK/illegal/bus timeout, and supports run/step/resume from the logic analyzer.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded at reset
//  MEM_TIMEOUT  255            max cycles waiting for imem/dmem ack before bus-error halt (1..255)
// PORTS
//  clk           in   1   core clock; only clock
//  rst_n         in   1   asynchronous, active-low reset
//  run_en        in   1   1 = free-run; 0 = execute only on step_req
//  step_req      in   1   1-cycle pulse: execute exactly one instruction while run_en=0
//  resume_req    in   1   1-cycle pulse: leave HALT (clears halt_cause)
//  imem_req      out  1   instruction fetch request, held until imem_ack
//  imem_addr     out  32  fetch address (= pc)
//  imem_ack      in   1   fetch complete; imem_rdata valid this cycle
//  imem_rdata    in   32  fetched instruction
//  dmem_req      out  1   data access request, held until dmem_ack
//  dmem_we       out  1   1 = store (opcode 0100011), 0 = load
//  dmem_ack      in   1   data access complete
//  instr         out  32  instruction register, to decoder
//  rs1_data      in   32  registered rs1 from datapath (JALR target)
//  immediate     in   32  decoded immediate
//  alu_output    in   32  datapath result; bit0 = branch-taken for opcode 1100011
//  rf_capture    out  1   1-cycle strobe: datapath samples rs1/rs2 on next posedge
//  reg_write     out  1   1-cycle writeback strobe
//  pc            out  32  current PC
//  halted        out  1   FSM in HALT
//  halt_cause    out  3   0 none,1 ECALL,2 EBREAK,3 illegal,4 misaligned,5 imem timeout,6 dmem timeout
//  instret       out  32  retired-instruction counter, wraps 0xFFFF_FFFF->0
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), instret=0, halt_cause=0, all strobes/req=0.
//  States: IDLE -> FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK -> IDLE; any -> HALT on fault.
//  IDLE: go to FETCH if run_en, or if step_req seen (step latched, consumed on entry to FETCH).
//  FETCH: imem_req=1, imem_addr=pc; on imem_ack latch instr, -> DECODE. Timeout counter reset each state entry.
//  DECODE: rf_capture=1 for one cycle; opcode not in RV32I base set -> HALT cause 3.
//  EXECUTE: one cycle for ALU settle. SYSTEM(1110011): imm==0 -> HALT cause1, imm==1 -> cause2; instr not retired.
//   Load/store -> MEMORY; else -> WRITEBACK.
//  MEMORY: dmem_req=1, dmem_we per opcode; on dmem_ack -> WRITEBACK.
//  WRITEBACK: reg_write=1 for opcodes LUI,AUIPC,JAL,JALR,OP,OP-IMM,LOAD; 0 for STORE/BRANCH/FENCE.
//   pc update same cycle: JAL pc+imm; JALR (rs1_data+imm)&~1; BRANCH pc+imm if alu_output[0] else pc+4; else pc+4.
//   If new pc[1:0]!=0 -> HALT cause 4, pc not updated, reg_write still asserted. instret += 1.
//  Arithmetic: all PC math modulo 2^32; pc+4 at 0xFFFF_FFFC wraps to 0.
//  Latency: 4 cycles + imem wait (ALU ops); 5 cycles + imem + dmem wait (loads/stores), with 0-wait acks.
//  Timeout: >= MEM_TIMEOUT cycles in FETCH/MEMORY without ack -> drop req, HALT cause 5/6.
//  Ack arriving same cycle as timeout expiry: ack wins.
//  HALT: all strobes 0, pc holds faulting instr address; resume_req -> IDLE, halt_cause=0.
//   Resume after cause 1/2 advances pc by 4 first.
//  step_req outside IDLE/HALT: latched, applied at next IDLE. step_req and resume_req together in HALT: resume only, step kept.
//  run_en falling mid-instruction: current instruction completes; stop at IDLE.
//  rst_n asserted mid-access: req drops immediately; pending ack after reset ignored.
// STRUCTURE
//  Package core_pkg: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE).
//  Package core_pkg also holds seq_state_t enum and halt_cause_t enum.
//  One sub-module: seq_timeout_ctr (8-bit load/decrement, expire flag) shared by FETCH and MEMORY.
// TESTING
//  ADDI x1,x0,5 with 0-wait imem -> rf_capture at cycle 2 after req, reg_write at cycle 4, pc 0->4, instret=1.
//  BEQ taken (alu_output=1, imm=16) at pc=0x20 -> pc=0x30, reg_write=0; not taken -> pc=0x24.
//  LW, dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, then reg_write pulse.
//  JALR rs1_data=0x103, imm=0 -> pc=0x102 -> HALT cause 4; resume_req -> IDLE.
//  imem_ack never arrives with MEM_TIMEOUT=8 -> HALT cause 5 after 8 cycles, imem_req=0.
//  run_en=0, two step_req pulses -> exactly 2 instructions retire (instret=2), FSM parks in IDLE.
//  EBREAK at 0x40 -> HALT cause 2, pc=0x40, instret unchanged; resume -> pc=0x44.
//  rst_n low mid-FETCH -> imem_req drops async, pc=RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: opcodes, FSM states,
// halt causes and small opcode classification helpers.
package core_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] FENCE  = 7'b0001111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_HALT
  } seq_state_t;

  typedef enum logic [2:0] {
    HC_NONE     = 3'd0,
    HC_ECALL    = 3'd1,
    HC_EBREAK   = 3'd2,
    HC_ILLEGAL  = 3'd3,
    HC_MISALIGN = 3'd4,
    HC_IMEM_TMO = 3'd5,
    HC_DMEM_TMO = 3'd6
  } halt_cause_t;

  function automatic logic is_rv32i_opcode(input logic [6:0] op);
    case (op)
      OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR,
      LUI, AUIPC, SYSTEM, FENCE: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      LUI, AUIPC, JAL, JALR, OP, OP_IMM, LOAD: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// Bus-wait watchdog: loaded on entry to a waiting state, counts down while
// waiting, and flags the last permitted cycle.
module seq_timeout_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic       o_expire
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  // A count of 1 while waiting means this is the final allowed cycle.
  assign o_expire = i_dec && (r_count == 8'd1);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the single-issue RV32I core: fetch, decode,
// execute, memory and writeback sequencing, next-PC and halt handling.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic        step_req,
  input  logic        resume_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] immediate,
  input  logic [31:0] alu_output,
  output logic        rf_capture,
  output logic        reg_write,
  output logic [31:0] pc,
  output logic        halted,
  output logic [2:0]  halt_cause,
  output logic [31:0] instret
);

  localparam logic [7:0] TMO_LOAD = 8'(MEM_TIMEOUT);

  seq_state_t  r_state;
  seq_state_t  w_next_state;
  halt_cause_t r_halt_cause;
  halt_cause_t w_fault_cause;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instret;
  logic        r_step_pending;
  logic [6:0]  w_opcode;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_target;
  logic        w_misaligned;
  logic        w_tmo_load;
  logic        w_tmo_dec;
  logic        w_tmo_expire;
  logic        w_unused;

  assign w_opcode     = r_instr[6:0];
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_misaligned = (w_pc_target[1:0] != 2'b00);
  assign w_unused     = ^alu_output[31:1];

  always_comb begin
    w_pc_target = w_pc_plus4;
    case (w_opcode)
      JAL:     w_pc_target = r_pc + immediate;
      JALR:    w_pc_target = (rs1_data + immediate) & ~32'd1;
      BRANCH:  w_pc_target = alu_output[0] ? (r_pc + immediate) : w_pc_plus4;
      default: w_pc_target = w_pc_plus4;
    endcase
  end

  always_comb begin
    w_next_state  = r_state;
    w_fault_cause = HC_NONE;
    case (r_state)
      S_IDLE: begin
        if (run_en || step_req || r_step_pending) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          w_next_state = S_DECODE;
        end else if (w_tmo_expire) begin
          w_next_state  = S_HALT;
          w_fault_cause = HC_IMEM_TMO;
        end
      end
      S_DECODE: begin
        if (!is_rv32i_opcode(w_opcode)) begin
          w_next_state  = S_HALT;
          w_fault_cause = HC_ILLEGAL;
        end else begin
          w_next_state = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        // SYSTEM never retires: ECALL/EBREAK halt, other encodings are unsupported.
        if (w_opcode == SYSTEM) begin
          w_next_state = S_HALT;
          if (immediate == 32'd0)      w_fault_cause = HC_ECALL;
          else if (immediate == 32'd1) w_fault_cause = HC_EBREAK;
          else                         w_fault_cause = HC_ILLEGAL;
        end else if ((w_opcode == LOAD) || (w_opcode == STORE)) begin
          w_next_state = S_MEMORY;
        end else begin
          w_next_state = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        if (dmem_ack) begin
          w_next_state = S_WRITEBACK;
        end else if (w_tmo_expire) begin
          w_next_state  = S_HALT;
          w_fault_cause = HC_DMEM_TMO;
        end
      end
      S_WRITEBACK: begin
        if (w_misaligned) begin
          w_next_state  = S_HALT;
          w_fault_cause = HC_MISALIGN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_HALT: begin
        if (resume_req) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_tmo_load = (w_next_state != r_state) &&
                      ((w_next_state == S_FETCH) || (w_next_state == S_MEMORY));
  assign w_tmo_dec  = (r_state == S_FETCH) || (r_state == S_MEMORY);

  seq_timeout_ctr u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmo_load),
    .i_load_val (TMO_LOAD),
    .i_dec      (w_tmo_dec),
    .o_expire   (w_tmo_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_instr        <= NOP_INSTR;
      r_step_pending <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_FETCH) && imem_ack) r_instr <= imem_rdata;
      // A step is remembered until the FSM actually starts a fetch.
      if ((r_state == S_IDLE) && (w_next_state == S_FETCH)) r_step_pending <= 1'b0;
      else if (step_req)                                   r_step_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_instret    <= 32'd0;
      r_halt_cause <= HC_NONE;
    end else begin
      if (r_state == S_WRITEBACK) begin
        r_instret <= r_instret + 32'd1;
        if (!w_misaligned) r_pc <= w_pc_target;
      end
      if ((r_state != S_HALT) && (w_next_state == S_HALT)) begin
        r_halt_cause <= w_fault_cause;
      end else if ((r_state == S_HALT) && resume_req) begin
        r_halt_cause <= HC_NONE;
        if ((r_halt_cause == HC_ECALL) || (r_halt_cause == HC_EBREAK)) r_pc <= w_pc_plus4;
      end
    end
  end

  assign imem_req   = (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == S_MEMORY);
  assign dmem_we    = (r_state == S_MEMORY) && (w_opcode == STORE);
  assign rf_capture = (r_state == S_DECODE);
  assign reg_write  = (r_state == S_WRITEBACK) && writes_rd(w_opcode);
  assign halted     = (r_state == S_HALT);
  assign halt_cause = r_halt_cause;
  assign instr      = r_instr;
  assign pc         = r_pc;
  assign instret    = r_instret;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: directed programs with hand-computed
// retire/halt expectations checked by an independent monitor.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_en, step_req, resume_req;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [31:0] imem_addr, imem_rdata, instr, rs1_data, immediate, alu_output;
  logic        rf_capture, reg_write, halted;
  logic [31:0] pc, instret;
  logic [2:0]  halt_cause;

  typedef struct {
    string       name;
    bit          isHalt;
    logic [31:0] pc;
    logic        regWrite;
    logic [2:0]  cause;
    logic [31:0] instret;
  } expEvent_t;

  expEvent_t   sbQueue[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] progMem [0:63];
  bit          imemAckEn = 1'b1;
  int          dmemWait = 0;
  int          dmemCnt = 0;
  int          imemRun = 0, dmemRun = 0, lastImemRun = 0, lastDmemRun = 0;
  logic        dmemWeSeen = 1'b0, lastDmemWe = 1'b0;
  logic [31:0] prevInstret = 32'd0;
  logic        prevHalted = 1'b0, prevRegWrite = 1'b0;

  core_sequencer #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .step_req(step_req),
    .resume_req(resume_req), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .instr(instr), .rs1_data(rs1_data),
    .immediate(immediate), .alu_output(alu_output), .rf_capture(rf_capture),
    .reg_write(reg_write), .pc(pc), .halted(halted), .halt_cause(halt_cause),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expectRetire(input string name, input logic [31:0] expPc,
                              input logic rw, input logic [31:0] ir);
    expEvent_t e;
    e.name = name; e.isHalt = 1'b0; e.pc = expPc; e.regWrite = rw;
    e.cause = 3'd0; e.instret = ir;
    sbQueue.push_back(e);
  endtask

  task automatic expectHalt(input string name, input logic [31:0] expPc,
                            input logic [2:0] cause, input logic [31:0] ir);
    expEvent_t e;
    e.name = name; e.isHalt = 1'b1; e.pc = expPc; e.regWrite = 1'b0;
    e.cause = cause; e.instret = ir;
    sbQueue.push_back(e);
  endtask

  task automatic scoreEvent(input bit isHalt);
    expEvent_t e;
    if (sbQueue.size() == 0) begin
      checkOutput(isHalt ? "unexpected_halt" : "unexpected_retire", 32'd1, 32'd0);
    end else begin
      e = sbQueue.pop_front();
      checkOutput({e.name, "_kind"}, {31'd0, isHalt}, {31'd0, e.isHalt});
      checkOutput({e.name, "_pc"}, pc, e.pc);
      checkOutput({e.name, "_instret"}, instret, e.instret);
      if (isHalt) checkOutput({e.name, "_cause"}, {29'd0, halt_cause}, {29'd0, e.cause});
      else        checkOutput({e.name, "_reg_write"}, {31'd0, prevRegWrite}, {31'd0, e.regWrite});
    end
  endtask

  // Monitor: retire = instret moved, halt = halted rose; also measures request lengths.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_req) imemRun++;
      else if (imemRun != 0) begin lastImemRun = imemRun; imemRun = 0; end
      if (dmem_req) begin dmemRun++; dmemWeSeen = dmem_we; end
      else if (dmemRun != 0) begin
        lastDmemRun = dmemRun; lastDmemWe = dmemWeSeen; dmemRun = 0;
      end
      if (rst_n) begin
        if (instret !== prevInstret) scoreEvent(1'b0);
        if (halted && !prevHalted)   scoreEvent(1'b1);
      end
      prevInstret  = instret;
      prevHalted   = halted;
      prevRegWrite = rst_n ? reg_write : 1'b0;
    end
  end

  // Memory responder: zero-wait imem, dmem ack after dmemWait idle cycles.
  initial begin
    imem_ack = 1'b0; imem_rdata = 32'd0; dmem_ack = 1'b0;
    forever begin
      @(negedge clk);
      imem_ack   = imem_req && imemAckEn;
      imem_rdata = progMem[imem_addr[7:2]];
      if (dmem_req) begin
        if (dmemCnt >= dmemWait) begin dmem_ack = 1'b1; dmemCnt = 0; end
        else begin dmem_ack = 1'b0; dmemCnt++; end
      end else begin
        dmem_ack = 1'b0; dmemCnt = 0;
      end
    end
  end

  task automatic waitDrain(input string name);
    for (int i = 0; i < 80; i++) begin
      if (sbQueue.size() == 0) break;
      @(negedge clk); #1;
    end
    checkOutput({name, "_drain"}, sbQueue.size(), 32'd0);
    sbQueue.delete();
  endtask

  task automatic applyStimulus(input string name, input logic [31:0] imm,
                               input logic [31:0] alu, input logic [31:0] rs1,
                               input int dWait);
    immediate = imm; alu_output = alu; rs1_data = rs1; dmemWait = dWait;
    @(negedge clk); step_req = 1'b1;
    @(negedge clk); step_req = 1'b0;
    waitDrain(name);
    repeat (2) @(negedge clk);
  endtask

  task automatic doResume(input string name, input logic [31:0] expPc);
    @(negedge clk); resume_req = 1'b1;
    @(negedge clk); resume_req = 1'b0;
    checkOutput({name, "_halted"}, {31'd0, halted}, 32'd0);
    checkOutput({name, "_cause"}, {29'd0, halt_cause}, 32'd0);
    checkOutput({name, "_pc"}, pc, expPc);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    run_en = 1'b0; step_req = 1'b0; resume_req = 1'b0;
    rs1_data = 32'd0; immediate = 32'd0; alu_output = 32'd0;
    for (int i = 0; i < 64; i++) progMem[i] = 32'h0000_0013;
    progMem[0]  = 32'h0050_0093;  // 0x00 ADDI x1,x0,5
    progMem[1]  = 32'h01C0_006F;  // 0x04 JAL x0,28
    progMem[8]  = 32'h0000_0863;  // 0x20 BEQ x0,x0,16
    progMem[9]  = 32'h0000_2103;  // 0x24 LW x2,0(x0)
    progMem[10] = 32'h0020_2223;  // 0x28 SW x2,4(x0)
    progMem[11] = 32'h0002_80E7;  // 0x2C JALR x1,0(x5)
    progMem[12] = 32'hFF1F_F06F;  // 0x30 JAL x0,-16
    progMem[16] = 32'h0010_0073;  // 0x40 EBREAK
    progMem[17] = 32'h0000_0073;  // 0x44 ECALL
    progMem[18] = 32'h0000_0000;  // 0x48 illegal opcode

    repeat (3) @(negedge clk);
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_instr", instr, 32'h0000_0013);
    checkOutput("reset_instret", instret, 32'h0);
    checkOutput("reset_cause", {29'd0, halt_cause}, 32'h0);
    checkOutput("reset_strobes", {27'd0, imem_req, dmem_req, rf_capture, reg_write, halted}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_no_fetch", {31'd0, imem_req}, 32'd0);

    // ADDI with cycle-accurate strobe timing
    expectRetire("addi", 32'h4, 1'b1, 32'd1);
    immediate = 32'd5; alu_output = 32'd5; rs1_data = 32'd0; dmemWait = 0;
    @(negedge clk); step_req = 1'b1;
    @(negedge clk); step_req = 1'b0;
    checkOutput("addi_c1_imem_req", {31'd0, imem_req}, 32'd1);
    checkOutput("addi_c1_imem_addr", imem_addr, 32'h0);
    @(negedge clk);
    checkOutput("addi_c2_rf_capture", {31'd0, rf_capture}, 32'd1);
    checkOutput("addi_c2_instr", instr, 32'h0050_0093);
    @(negedge clk);
    checkOutput("addi_c3_strobes", {30'd0, rf_capture, reg_write}, 32'd0);
    @(negedge clk);
    checkOutput("addi_c4_reg_write", {31'd0, reg_write}, 32'd1);
    waitDrain("addi");
    repeat (2) @(negedge clk);

    expectRetire("jal_fwd", 32'h20, 1'b1, 32'd2);
    applyStimulus("jal_fwd", 32'd28, 32'd0, 32'd0, 0);
    expectRetire("beq_taken", 32'h30, 1'b0, 32'd3);
    applyStimulus("beq_taken", 32'd16, 32'd1, 32'd0, 0);
    expectRetire("jal_back", 32'h20, 1'b1, 32'd4);
    applyStimulus("jal_back", 32'hFFFF_FFF0, 32'd0, 32'd0, 0);
    expectRetire("beq_not_taken", 32'h24, 1'b0, 32'd5);
    applyStimulus("beq_not_taken", 32'd16, 32'd0, 32'd0, 0);

    expectRetire("lw", 32'h28, 1'b1, 32'd6);
    applyStimulus("lw", 32'd0, 32'd0, 32'd0, 3);
    checkOutput("lw_dmem_req_cycles", lastDmemRun, 32'd4);
    checkOutput("lw_dmem_we", {31'd0, lastDmemWe}, 32'd0);
    expectRetire("sw", 32'h2C, 1'b0, 32'd7);
    applyStimulus("sw", 32'd4, 32'd0, 32'd0, 0);
    checkOutput("sw_dmem_req_cycles", lastDmemRun, 32'd1);
    checkOutput("sw_dmem_we", {31'd0, lastDmemWe}, 32'd1);

    expectRetire("jalr_misalign_wb", 32'h2C, 1'b1, 32'd8);
    expectHalt("jalr_misalign", 32'h2C, 3'd4, 32'd8);
    applyStimulus("jalr_misalign", 32'd0, 32'd0, 32'h103, 0);
    doResume("resume_misalign", 32'h2C);
    expectRetire("jalr_ok", 32'h40, 1'b1, 32'd9);
    applyStimulus("jalr_ok", 32'd0, 32'd0, 32'h40, 0);

    expectHalt("ebreak", 32'h40, 3'd2, 32'd9);
    applyStimulus("ebreak", 32'd1, 32'd0, 32'd0, 0);
    doResume("resume_ebreak", 32'h44);
    expectHalt("ecall", 32'h44, 3'd1, 32'd9);
    applyStimulus("ecall", 32'd0, 32'd0, 32'd0, 0);
    doResume("resume_ecall", 32'h48);
    expectHalt("illegal", 32'h48, 3'd3, 32'd9);
    applyStimulus("illegal", 32'd0, 32'd0, 32'd0, 0);
    doResume("resume_illegal", 32'h48);

    imemAckEn = 1'b0;
    expectHalt("imem_timeout", 32'h48, 3'd5, 32'd9);
    applyStimulus("imem_timeout", 32'd0, 32'd0, 32'd0, 0);
    checkOutput("imem_timeout_req_cycles", lastImemRun, 32'd8);
    checkOutput("imem_timeout_req_dropped", {31'd0, imem_req}, 32'd0);
    imemAckEn = 1'b1;
    doResume("resume_timeout", 32'h48);

    // Two steps, the second arriving mid-instruction and latched
    progMem[18] = 32'h0010_0193;
    progMem[19] = 32'h0010_0193;
    progMem[20] = 32'h0010_0193;
    progMem[21] = 32'h0010_0193;
    immediate = 32'd1; alu_output = 32'd1;
    expectRetire("step1", 32'h4C, 1'b1, 32'd10);
    expectRetire("step2", 32'h50, 1'b1, 32'd11);
    @(negedge clk); step_req = 1'b1;
    @(negedge clk); step_req = 1'b0;
    @(negedge clk); step_req = 1'b1;
    @(negedge clk); step_req = 1'b0;
    waitDrain("two_steps");
    repeat (10) @(negedge clk);
    checkOutput("two_steps_instret", instret, 32'd11);
    checkOutput("two_steps_parked", {31'd0, imem_req}, 32'd0);

    // run_en dropped during DECODE: the instruction still completes, then park
    expectRetire("run_drop", 32'h54, 1'b1, 32'd12);
    @(negedge clk); run_en = 1'b1;
    @(negedge clk);
    @(negedge clk); run_en = 1'b0;
    waitDrain("run_drop");
    repeat (10) @(negedge clk);
    checkOutput("run_drop_instret", instret, 32'd12);
    checkOutput("run_drop_parked", {31'd0, imem_req}, 32'd0);

    // Reset asserted while a fetch is outstanding
    imemAckEn = 1'b0;
    @(negedge clk); step_req = 1'b1;
    @(negedge clk); step_req = 1'b0;
    checkOutput("rst_mid_fetch_req_before", {31'd0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_fetch_req_dropped", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_mid_fetch_pc", pc, 32'h0);
    checkOutput("rst_mid_fetch_instret", instret, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    imemAckEn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_idle", {31'd0, imem_req}, 32'd0);

    expectRetire("addi_after_reset", 32'h4, 1'b1, 32'd1);
    applyStimulus("addi_after_reset", 32'd5, 32'd5, 32'd0, 0);

    checkOutput("scoreboard_empty", sbQueue.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
